// File: rtl/sev_seg_pkg.sv
// Shared constants, converter state encoding and decimal helpers for the
// seven-segment display feeder.
`timescale 1ns/1ps
package sev_seg_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/double_dabble_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per SHIFT cycle,
// with saturation of inputs beyond the displayable range.
`timescale 1ns/1ps
module double_dabble_conv
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    bin_valid,
    output logic                    bin_ready,
    output logic                    done,
    output logic                    ovf_next,
    output logic [4*NUM_DIGITS-1:0] digits
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    conv_state_t        state, state_nxt;
    logic [CNT_W-1:0]   cnt_p0;
    logic [BIN_W-1:0]   bin_p0;
    logic [BCD_W-1:0]   bcd_p0;
    logic               ovf_p0;
    logic               accept;

    function automatic logic is_over(input logic [BIN_W-1:0] v);
        return 64'(v) > MAX_VAL;
    endfunction

    function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
        logic [63:0] sat;
        sat = is_over(v) ? MAX_VAL : 64'(v);
        return sat[BIN_W-1:0];
    endfunction

    // Add 3 to every nibble of 5 or more so the following shift carries correctly.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign accept = bin_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_p0 <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_p0 <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                cnt_p0 <= cnt_p0 - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bin_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt_p0 == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bin_ready = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE:    bin_ready = 1'b1;
            COMMIT:  done      = 1'b1;
            default: ;
        endcase
    end

    // p0: operand capture and shift-add-3 iterations
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_p0 <= saturate(bin_in);
            bcd_p0 <= '0;
            ovf_p0 <= is_over(bin_in);
        end else if (state == SHIFT) begin
            {bcd_p0, bin_p0} <= {dabble_step(bcd_p0), bin_p0} << 1;
        end
    end

    assign digits   = bcd_p0;
    assign ovf_next = ovf_p0;

endmodule

// File: rtl/bcd_digit_scanner.sv
// Converts a binary value to BCD digits and time-multiplexes them onto one bcd bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (bcd = 4'hF).
`timescale 1ns/1ps
module bcd_digit_scanner
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic                  conv_done,
    output logic                  ovf,
    output logic [3:0]            bcd,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [BCD_W-1:0] conv_digits;
    logic             conv_ovf;
    logic [BCD_W-1:0] disp_p1, disp_nxt;
    logic [PRE_W-1:0] pre_p1;
    logic [IDX_W-1:0] idx_p1, idx_nxt;
    logic             tc;

    double_dabble_conv #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .done      (conv_done),
        .ovf_next  (conv_ovf),
        .digits    (conv_digits)
    );

    function automatic logic [3:0] digit_out(input logic [BCD_W-1:0] d,
                                             input logic [IDX_W-1:0] i);
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and everything above it is zero; digit 0 always shows.
        if (i != '0 && (d >> (4 * int'(i))) == '0) begin
            return BCD_BLANK;
        end
`endif
        return d[4 * int'(i) +: 4];
    endfunction

    always_comb begin
        tc       = (pre_p1 == PRE_W'(SCAN_DIV - 1));
        idx_nxt  = idx_p1;
        if (tc) begin
            idx_nxt = (idx_p1 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p1 + IDX_W'(1);
        end
        disp_nxt = conv_done ? conv_digits : disp_p1;
    end

    // p1: display register, scan position and registered digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_p1   <= '0;
            idx_p1   <= '0;
            disp_p1  <= '0;
            ovf      <= 1'b0;
            bcd      <= 4'd0;
            digit_en <= NUM_DIGITS'(1);
        end else begin
            pre_p1   <= tc ? '0 : pre_p1 + PRE_W'(1);
            idx_p1   <= idx_nxt;
            disp_p1  <= disp_nxt;
            ovf      <= conv_done ? conv_ovf : ovf;
            bcd      <= digit_out(disp_nxt, idx_nxt);
            digit_en <= NUM_DIGITS'(1) << idx_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner: table vectors, hand sequences and
// randomized traffic against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_digit_scanner;

    localparam int ND   = 4;
    localparam int BW   = 14;
    localparam int SDIV = 4;
    localparam int MAXV = 9999;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
    localparam bit BLANK = 1'b1;
`else
    localparam logic [3:0] LZ = 4'h0;
    localparam bit BLANK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] bin_in = '0;
    logic          bin_valid = 1'b0;
    logic          bin_ready, conv_done, ovf;
    logic [3:0]    bcd;
    logic [ND-1:0] digit_en;

    int checks = 0;
    int passes = 0;

    bcd_digit_scanner #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
        .bin_ready(bin_ready), .conv_done(conv_done), .ovf(ovf),
        .bcd(bcd), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    // Reference model: transaction countdown plus decimal value of the display.
    int m_edges = 0, m_busy = 0, m_pend = 0, m_disp = 0;
    bit m_ovf = 0, m_pend_ovf = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_edges <= 0; m_busy <= 0; m_disp <= 0; m_ovf <= 0;
        end else begin
            m_edges <= m_edges + 1;
            if (m_busy == 1) begin
                m_disp <= m_pend; m_ovf <= m_pend_ovf; m_busy <= 0;
            end else if (m_busy > 1) begin
                m_busy <= m_busy - 1;
            end else if (bin_valid) begin
                m_busy     <= BW + 1;
                m_pend     <= (int'(bin_in) > MAXV) ? MAXV : int'(bin_in);
                m_pend_ovf <= int'(bin_in) > MAXV;
            end
        end
    end

    function automatic logic [3:0] exp_digit(input int v, input int i);
        int p;
        p = 10 ** i;
        if (BLANK && i > 0 && v < p) return 4'hF;
        return 4'((v / p) % 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        idx = (m_edges / SDIV) % ND;
        chk("bin_ready", 32'(bin_ready), 32'(m_busy == 0));
        chk("conv_done", 32'(conv_done), 32'(m_busy == 1));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("digit_en", 32'(digit_en), 32'(1 << idx));
        chk("bcd", 32'(bcd), 32'(exp_digit(m_disp, idx)));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bin_ready !== 1'b1 && n < 40) begin tick(); n++; end
        chk("wait_ready", 32'(bin_ready), 32'd1);
    endtask

    task automatic apply(input int v);
        wait_ready();
        bin_in = BW'(v); bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
    endtask

    task automatic capture(output logic [15:0] got);
        got = '0;
        for (int c = 0; c < 4 * SDIV; c++) begin
            tick();
            for (int i = 0; i < ND; i++) if (digit_en[i]) got[4*i +: 4] = bcd;
        end
    endtask

    typedef struct { int val; logic [15:0] exp; bit eovf; } vec_t;
    vec_t tbl[10];

    initial begin
        logic [15:0] got;
        int seen;

        tbl[0] = '{1234,  {4'd1, 4'd2, 4'd3, 4'd4}, 1'b0};
        tbl[1] = '{12000, 16'h9999,                 1'b1};
        tbl[2] = '{42,    {LZ, LZ, 4'd4, 4'd2},     1'b0};
        tbl[3] = '{40,    {LZ, LZ, 4'd4, 4'd0},     1'b0};
        tbl[4] = '{0,     {LZ, LZ, LZ, 4'd0},       1'b0};
        tbl[5] = '{9999,  16'h9999,                 1'b0};
        tbl[6] = '{10000, 16'h9999,                 1'b1};
        tbl[7] = '{305,   {LZ, 4'd3, 4'd0, 4'd5},   1'b0};
        tbl[8] = '{16383, 16'h9999,                 1'b1};
        tbl[9] = '{7,     {LZ, LZ, LZ, 4'd7},       1'b0};

        // Reset
        repeat (3) tick();
        chk("rst_ready", 32'(bin_ready), 32'd1);
        chk("rst_digit_en", 32'(digit_en), 32'b0001);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_done", 32'(conv_done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency of 1234: done only in cycle N+15, ready back in N+16
        apply(1234);
        for (int k = 1; k <= 16; k++) begin
            chk("lat_ready", 32'(bin_ready), 32'(k == 16));
            chk("lat_done", 32'(conv_done), 32'(k == 15));
            tick();
        end

        // Table vectors
        foreach (tbl[t]) begin
            apply(tbl[t].val);
            wait_ready();
            chk("tbl_ovf", 32'(ovf), 32'(tbl[t].eovf));
            capture(got);
            for (int i = 0; i < ND; i++)
                chk("tbl_digit", 32'(got[4*i +: 4]), 32'(tbl[t].exp[4*i +: 4]));
        end

        // Valid while busy is ignored
        apply(5);
        repeat (3) tick();
        bin_in = BW'(77); bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        wait_ready();
        capture(got);
        chk("busy_ignore", 32'(got), 32'({LZ, LZ, LZ, 4'd5}));
        for (int k = 0; k < 4; k++) begin
            chk("ready_hold", 32'(bin_ready), 32'd1);
            tick();
        end
        apply(8);
        chk("ready_drop", 32'(bin_ready), 32'd0);
        wait_ready();

        // Reset mid-SHIFT aborts conversion
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_digit_en", 32'(digit_en), 32'b0001);
        chk("abort_bcd", 32'(bcd), 32'd0);
        apply(9999);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_en2", 32'(digit_en), 32'b0001);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (conv_done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        capture(got);
        chk("abort_disp", 32'(got), 32'({LZ, LZ, LZ, 4'd0}));

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            bin_valid = ($urandom_range(0, 3) == 0);
            bin_in    = $urandom_range(0, 1) ? BW'($urandom_range(0, MAXV))
                                             : BW'($urandom_range(0, 16383));
            tick();
        end
        rst_n = 1'b1; bin_valid = 1'b0;
        wait_ready();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
